// File: rtl/sram_bus_ctrl.sv
// AVR-to-SRAM bus bridge: serial address load, address auto-increment, wait-stated read/write FSM.
// Optional SNES pass-through is compiled in with `define SNES_MODE_EN.
module sram_bus_ctrl #(
  parameter int ADDR_W      = 21,
  parameter int DATA_W      = 8,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              avr_clk,
  input  logic              avr_reset,
  input  logic              avr_si,
  input  logic              avr_sreg_en_n,
  input  logic              avr_counter_n,
  input  logic              avr_oe_n,
  input  logic              avr_we_n,
  input  logic [DATA_W-1:0] avr_data_in,
  output logic [DATA_W-1:0] avr_data_out,
  output logic              avr_data_oe,
  input  logic [DATA_W-1:0] sram_data_in,
  output logic [DATA_W-1:0] sram_data_out,
  output logic              sram_data_oe,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              busy,
  output logic              err,
`ifdef SNES_MODE_EN
  input  logic              snes_mode,
  input  logic [ADDR_W-1:0] snes_addr,
  input  logic              snes_rd_n,
`endif
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    IDLE, RD_SETUP, RD_WAIT, RD_LATCH, WR_SETUP, WR_PULSE, WR_HOLD, RECOVER
  } state_t;

  state_t            state, next_state;
  logic [ADDR_W-1:0] addr;
  logic [4:0]        wait_cnt;
  logic [1:0]        oe_sy, we_sy, cnt_sy;
  logic              we_prev, cnt_prev;
  logic              oe_s, we_s, cnt_s, we_fall, cnt_fall;
  logic              wr_pend, inc_pend, inc_apply;
  logic              start_wr, conflict;
  logic              ce_c, oe_c, we_c, doe_c;
  logic              snes_block;

  // Requests are levels/edges on the synchronised pins; the AVR never waits on a ready.
  assign oe_s     = oe_sy[1];
  assign we_s     = we_sy[1];
  assign cnt_s    = cnt_sy[1];
  assign we_fall  = we_prev & ~we_s;
  assign cnt_fall = cnt_prev & ~cnt_s;
  assign inc_apply = (state == IDLE) && avr_sreg_en_n && inc_pend;

  always_ff @(posedge avr_clk or posedge avr_reset) begin
    if (avr_reset) begin
      oe_sy    <= 2'b11;
      we_sy    <= 2'b11;
      cnt_sy   <= 2'b11;
      we_prev  <= 1'b1;
      cnt_prev <= 1'b1;
    end else begin
      oe_sy    <= {oe_sy[0], avr_oe_n};
      we_sy    <= {we_sy[0], avr_we_n};
      cnt_sy   <= {cnt_sy[0], avr_counter_n};
      we_prev  <= we_s;
      cnt_prev <= cnt_s;
    end
  end

`ifdef SNES_MODE_EN
  logic snes_act;
  assign snes_block = snes_mode | snes_act;

  always_ff @(posedge avr_clk or posedge avr_reset) begin
    if (avr_reset)         snes_act <= 1'b0;
    else if (!snes_mode)   snes_act <= 1'b0;
    else if (state == IDLE) snes_act <= 1'b1;
  end
`else
  assign snes_block = 1'b0;
`endif

  always_comb begin
    next_state = state;
    start_wr   = 1'b0;
    conflict   = 1'b0;
    ce_c       = 1'b1;
    oe_c       = 1'b1;
    we_c       = 1'b1;
    doe_c      = 1'b0;
    case (state)
      IDLE: begin
        if (!snes_block) begin
          if (!oe_s && !we_s) begin
            conflict = 1'b1;
          end else if (we_fall || wr_pend) begin
            start_wr   = 1'b1;
            next_state = WR_SETUP;
          end else if (!oe_s) begin
            next_state = RD_SETUP;
          end
        end
      end
      RD_SETUP: begin
        ce_c = 1'b0;
        oe_c = 1'b0;
        next_state = (WAIT_CYCLES == 0) ? RD_LATCH : RD_WAIT;
      end
      RD_WAIT: begin
        ce_c = 1'b0;
        oe_c = 1'b0;
        if (wait_cnt == 5'(WAIT_CYCLES - 1)) next_state = RD_LATCH;
      end
      RD_LATCH: begin
        ce_c = 1'b0;
        next_state = RECOVER;
      end
      WR_SETUP: begin
        ce_c  = 1'b0;
        doe_c = 1'b1;
        next_state = WR_PULSE;
      end
      WR_PULSE: begin
        ce_c  = 1'b0;
        we_c  = 1'b0;
        doe_c = 1'b1;
        if (wait_cnt == 5'(WAIT_CYCLES)) next_state = WR_HOLD;
      end
      WR_HOLD: begin
        ce_c  = 1'b0;
        doe_c = 1'b1;
        next_state = RECOVER;
      end
      RECOVER: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge avr_clk or posedge avr_reset) begin
    if (avr_reset) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      addr          <= '0;
      avr_data_out  <= '0;
      sram_data_out <= '0;
      wr_pend       <= 1'b0;
      inc_pend      <= 1'b0;
      err           <= 1'b0;
    end else begin
      state    <= next_state;
      wait_cnt <= (next_state != state) ? 5'd0 : wait_cnt + 5'd1;
      if (next_state == RD_LATCH && state != RD_LATCH) avr_data_out <= sram_data_in;
      if (start_wr) sram_data_out <= avr_data_in;

      // One-deep write queue; an edge that finds it full is lost and flagged.
      if (conflict) begin
        err     <= 1'b1;
        wr_pend <= 1'b0;
      end else if (start_wr) begin
        wr_pend <= wr_pend & we_fall;
      end else if (we_fall && !snes_block) begin
        if (wr_pend) err <= 1'b1;
        else         wr_pend <= 1'b1;
      end

      if (!avr_sreg_en_n) begin
        if (state == IDLE) addr <= {addr[ADDR_W-2:0], avr_si};
        else               err  <= 1'b1;
      end else if (inc_apply) begin
        addr <= addr + ADDR_W'(1);
      end

      if (cnt_fall)       inc_pend <= 1'b1;
      else if (inc_apply) inc_pend <= 1'b0;
    end
  end

  assign avr_data_oe = ~oe_s & we_s;
  assign busy        = (state != IDLE);
  assign dbg_state   = state;

`ifdef SNES_MODE_EN
  assign sram_addr    = snes_act ? snes_addr : addr;
  assign sram_ce_n    = snes_act ? snes_rd_n : ce_c;
  assign sram_oe_n    = snes_act ? snes_rd_n : oe_c;
  assign sram_we_n    = snes_act | we_c;
  assign sram_data_oe = ~snes_act & doe_c;
`else
  assign sram_addr    = addr;
  assign sram_ce_n    = ce_c;
  assign sram_oe_n    = oe_c;
  assign sram_we_n    = we_c;
  assign sram_data_oe = doe_c;
`endif

endmodule

// File: doc/sram_bus_ctrl.md
Name: sram_bus_ctrl

Overview:
Parametrised successor of the AVR-to-SRAM bus path. It combines four functions in one block:
- serial address shift register
- address auto-increment counter
- read/write bus FSM with configurable wait states
- request synchronisers

It sits between the AVR port pins and the SRAM pins. Tristating is done at the top level using the *_oe outputs.

Parameters:
ADDR_W, 21, width of the SRAM address and shift register
DATA_W, 8, width of the data bus
WAIT_CYCLES, 1, extra SRAM access cycles (0..15) inserted in the read and write strobes

Ports:
avr_clk  input  1  system clock; all logic is on the rising edge
avr_reset  input  1  asynchronous, active-high reset
avr_si  input  1  serial address bit, MSB first
avr_sreg_en_n  input  1  low = shift avr_si into the address register
avr_counter_n  input  1  a falling edge increments the address
avr_oe_n  input  1  low = read request (level-sensitive)
avr_we_n  input  1  falling edge = write request
avr_data_in  input  DATA_W  write data from the AVR
avr_data_out  output  DATA_W  last byte read from SRAM
avr_data_oe  output  1  drive avr_data_out onto the AVR bus
sram_data_in  input  DATA_W  SRAM read data
sram_data_out  output  DATA_W  SRAM write data
sram_data_oe  output  1  drive sram_data_out
sram_addr  output  ADDR_W  SRAM address
sram_ce_n, sram_oe_n, sram_we_n  output  1 each  SRAM strobes, active low
busy  output  1  FSM is not in IDLE
err  output  1  sticky protocol error flag, cleared only by reset

Behaviour:
- Reset values:
  - address register = 0, avr_data_out = 0, sram_data_out = 0
  - all *_n strobes = 1, all *_oe = 0
  - busy = 0, err = 0, FSM = IDLE
- Reset asserted mid-transaction forces all of these values immediately, asynchronously.
- Synchronisers: avr_oe_n, avr_we_n and avr_counter_n each pass through a 2-flop synchroniser. Falling edges are detected on the synchronised value.
  - avr_si and avr_sreg_en_n are sampled directly; the AVR guarantees setup time.
- Shift register: each clock with avr_sreg_en_n=0 and FSM in IDLE:
  - addr <= {addr[ADDR_W-2:0], avr_si}.
  - If avr_sreg_en_n=0 while busy, the shift is dropped and err is set.
- Counter: a synchronised falling edge of avr_counter_n sets pending_inc.
  - pending_inc is applied in IDLE as addr <= addr+1, modulo 2^ADDR_W (all ones wraps to 0).
  - Shift has priority: an increment coinciding with an active shift stays pending until avr_sreg_en_n=1.
- Address: sram_addr = address register. It is stable for the whole transaction.
- FSM states: IDLE, RD_SETUP, RD_WAIT, RD_LATCH, WR_SETUP, WR_PULSE, WR_HOLD, RECOVER.
- Read path:
  - IDLE, synced oe_n=0, we_n=1 -> RD_SETUP (ce_n=0, oe_n=0).
  - RD_SETUP -> RD_WAIT, held WAIT_CYCLES cycles (skipped if 0).
  - RD_WAIT -> RD_LATCH: avr_data_out <= sram_data_in.
  - RD_LATCH -> RECOVER (strobes=1) -> IDLE.
- Read repeat: while oe_n stays low, reads repeat back-to-back and refresh avr_data_out.
- Read latency: synced request to data = 2 + WAIT_CYCLES cycles.
- avr_data_oe = synced oe_n low AND we_n high.
- Write path:
  - On a we_n falling edge in IDLE, latch avr_data_in into sram_data_out, then -> WR_SETUP (ce_n=0, sram_data_oe=1).
  - WR_SETUP -> WR_PULSE: we_n=0 for WAIT_CYCLES+1 cycles.
  - WR_PULSE -> WR_HOLD: we_n=1, data still driven.
  - WR_HOLD -> RECOVER: sram_data_oe=0 -> IDLE.
  - Exactly one write per we_n falling edge. A falling edge seen while busy is held pending (one deep). A second edge while one is pending sets err and is dropped.
- Simultaneous requests: synced oe_n=0 and we_n=0 together -> no transaction, err set.
- Exclusivity: sram_oe_n and sram_we_n are never low in the same cycle. sram_data_oe is never 1 while sram_oe_n=0.

Optional Feature:
SNES_MODE_EN
- With the macro: adds input ports snes_mode (1), snes_addr (ADDR_W) and snes_rd_n (1).
  - snes_mode is sampled only in IDLE.
  - Once mode is active: sram_addr = snes_addr, sram_ce_n = sram_oe_n = snes_rd_n (combinational), sram_data_oe = 0, and AVR requests are ignored (not queued).
  - Leaving the mode returns to IDLE on the next clock.
- Without the macro: these ports and their logic are absent.

Test Plan:
- Reset, then 16 shifts of bits 0100110011001111 with avr_sreg_en_n=0 -> sram_addr=0x004CCF.
- Addr 0x004CCF, SRAM drives 0xAA, oe_n low, WAIT_CYCLES=1 -> sram_oe_n low for 2 cycles, avr_data_out=0xAA. SRAM then changes to 0xBB with oe_n held low -> next read returns 0xBB.
- avr_data_in=0xEE, one we_n falling edge -> sram_we_n low exactly 2 cycles, sram_data_out=0xEE, no second write, sram_oe_n stays 1.
- Addr 0x1FFFFF, avr_counter_n pulse -> addr=0x000000. Counter pulse during a write -> increment applied after RECOVER.
- oe_n and we_n low together -> no strobes, err=1. avr_reset asserted during WR_PULSE -> sram_we_n=1 and sram_data_oe=0 immediately.
- With SNES_MODE_EN: snes_mode=1, snes_addr=0x012345, snes_rd_n=0 -> sram_addr=0x012345 and sram_oe_n=0. An avr_oe_n request in this mode is ignored.
